// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch slice: FSM states, line geometry, queue entry type.
package fetch_pkg;

  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned LINE_BITS  = 128;
  localparam int unsigned WSEL_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } qentry_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction FIFO of {pc, inst}: up to LINE_WORDS pushes per cycle, single pop, flush, free count.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic [2:0]                    push_count,
  input  qentry_t [LINE_WORDS-1:0]      push_data,
  input  logic                          pop,
  output logic                          head_valid,
  output qentry_t                       head,
  output logic [$clog2(DEPTH):0]        free
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  qentry_t        mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [CW-1:0]  count;
  logic           pop_ok;

  assign pop_ok     = pop && (count != '0);
  assign head_valid = (count != '0);
  assign head       = mem[rd_ptr];
  assign free       = CW'(DEPTH) - count;

  always_ff @(posedge clock) begin
    if (!flush) begin
      for (int unsigned i = 0; i < LINE_WORDS; i++) begin
        if (i < 32'(push_count)) mem[wr_ptr + AW'(i)] <= push_data[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_count);
      rd_ptr <= rd_ptr + AW'(pop_ok);
      count  <= count + CW'(push_count) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, one-outstanding icache line requests, line split into an instruction queue.
// Optional stall counter output enabled by defining FETCH_STALL_COUNT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  output logic [31:0]          icache_address,
  output logic                 icache_read,
  input  logic [LINE_BITS-1:0] icache_data,
  input  logic                 icache_ack,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_target,
  output logic                 inst_valid,
  output logic [31:0]          inst,
  output logic [31:0]          inst_pc,
  input  logic                 inst_ready
`ifdef FETCH_STALL_COUNT_EN
  ,
  output logic [31:0]          stall_count
`endif
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_t            state;
  logic [31:2]             pc;
  logic                    drop;
  logic [WSEL_W-1:0]       off;
  logic                    accept;
  logic [2:0]              push_count;
  qentry_t [LINE_WORDS-1:0] push_data;
  logic                    head_valid;
  qentry_t                 head;
  logic [CW-1:0]           free;
  logic                    unused_tgt_lsb;

  assign unused_tgt_lsb = ^redirect_target[1:0];
  assign off            = pc[3:2];
  assign accept         = (state == ST_WAIT) && icache_ack && !drop && !redirect_valid;
  assign push_count     = accept ? (3'(LINE_WORDS) - {1'b0, off}) : 3'd0;

  // Slot j carries word (off + j); only the first push_count slots are written.
  always_comb begin
    push_data = '0;
    for (int unsigned j = 0; j < LINE_WORDS; j++) begin
      push_data[j].pc   = {pc[31:4], off + WSEL_W'(j), 2'b00};
      push_data[j].inst = icache_data[{off + WSEL_W'(j), 5'b0} +: 32];
    end
  end

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (redirect_valid),
    .push_count (push_count),
    .push_data  (push_data),
    .pop        (inst_ready),
    .head_valid (head_valid),
    .head       (head),
    .free       (free)
  );

  assign inst_valid = head_valid;
  assign inst       = head_valid ? head.inst : '0;
  assign inst_pc    = head_valid ? head.pc   : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      pc             <= RESET_PC[31:2];
      drop           <= 1'b0;
      icache_read    <= 1'b0;
      icache_address <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (redirect_valid) begin
            pc <= redirect_target[31:2];
          end else if (free >= CW'(LINE_WORDS)) begin
            state          <= ST_REQ;
            icache_read    <= 1'b1;
            icache_address <= {4'b0, pc[31:4]};
          end
        end
        ST_REQ: begin
          icache_read <= 1'b0;
          state       <= ST_WAIT;
          if (redirect_valid) begin
            pc   <= redirect_target[31:2];
            drop <= 1'b1;
          end
        end
        ST_WAIT: begin
          // A redirect racing the ack consumes the ack itself, so nothing is left to drain.
          if (redirect_valid) begin
            pc <= redirect_target[31:2];
            if (icache_ack) begin
              state <= ST_IDLE;
              drop  <= 1'b0;
            end else begin
              drop <= 1'b1;
            end
          end else if (icache_ack) begin
            state <= ST_IDLE;
            drop  <= 1'b0;
            if (!drop) pc <= {pc[31:4] + 28'd1, 2'b00};
          end
        end
        default: begin
          state       <= ST_IDLE;
          icache_read <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_STALL_COUNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) stall_count <= '0;
    else if (state == ST_WAIT) stall_count <= stall_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: bench acts as icache and decode, model predicts the word stream.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [31:0]  icache_address;
  logic         icache_read;
  logic [127:0] icache_data = '0;
  logic         icache_ack = 1'b0;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_target = '0;
  logic         inst_valid;
  logic [31:0]  inst;
  logic [31:0]  inst_pc;
  logic         inst_ready = 1'b0;
`ifdef FETCH_STALL_COUNT_EN
  logic [31:0]  stall_count;
`endif

  always #5 clock = ~clock;

  fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .icache_address  (icache_address),
    .icache_read     (icache_read),
    .icache_data     (icache_data),
    .icache_ack      (icache_ack),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready)
`ifdef FETCH_STALL_COUNT_EN
    ,
    .stall_count     (stall_count)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        expq[$];
  int          checks = 0;
  int          passes = 0;
  logic [31:0] mpc;
  bit          outstanding = 0;
  bit          dropped = 0;
  int          waitc = 0;
  int          reads = 0;
  int          pops = 0;
  int          ready_pct = 100;
  int          redir_pct = 0;
  int          max_lat = 1;
  int          fmode = 0;
  int          flat = 0;
  logic [31:0] ftgt = '0;
  logic [31:0] exp_stall = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 1023));
      1:       return 32'hFFFF_FFC0 + 32'($urandom_range(0, 63));
      default: return 32'($urandom);
    endcase
  endfunction

  // One cycle: observe outputs just after the edge, then drive this cycle's inputs and update the model.
  task automatic step();
    bit          ack_now;
    bit          redir;
    logic [31:0] tgt;
    logic [31:0] w;
    @(posedge clock);
    #2;
    ack_now = 0;
`ifdef FETCH_STALL_COUNT_EN
    chk("stall_count", stall_count, exp_stall);
    if (outstanding && !icache_read) exp_stall++;
`endif
    if (icache_read) begin
      chk("one_outstanding", 32'(outstanding), 32'd0);
      chk("read_addr", icache_address, {4'b0, mpc[31:4]});
      chk("free_before_req", 32'(expq.size() <= DEPTH - 4), 32'd1);
      outstanding = 1;
      dropped     = 0;
      waitc       = (flat != 0) ? flat : $urandom_range(1, max_lat);
      flat        = 0;
      reads++;
    end else if (outstanding) begin
      waitc--;
      if (waitc == 0) ack_now = 1;
    end
    redir = ($urandom_range(0, 99) < redir_pct);
    tgt   = pick_target();
    if (fmode == 1 || (fmode == 2 && outstanding && !icache_read && !ack_now) ||
        (fmode == 3 && ack_now)) begin
      redir = 1;
      tgt   = ftgt;
      fmode = 0;
    end
    icache_data = {$urandom, $urandom, $urandom, $urandom};
    icache_ack  = ack_now;
    if (ack_now) begin
      outstanding = 0;
      if (!redir && !dropped) begin
        for (int k = int'(mpc[3:2]); k < 4; k++) begin
          w = k;
          expq.push_back('{pc: {mpc[31:4], w[1:0], 2'b00}, ins: icache_data[32*k +: 32]});
        end
        mpc = {mpc[31:4] + 28'd1, 4'b0};
      end
    end
    redirect_valid  = redir;
    redirect_target = tgt;
    if (redir) begin
      expq.delete();
      mpc = {tgt[31:2], 2'b00};
      if (outstanding) dropped = 1;
    end
    inst_ready = ($urandom_range(0, 99) < ready_pct);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_outputs();
    chk("rst_icache_read", 32'(icache_read), 32'd0);
    chk("rst_icache_address", icache_address, 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
`ifdef FETCH_STALL_COUNT_EN
    chk("rst_stall_count", stall_count, 32'd0);
`endif
  endtask

  // Release reset and present a stray ack while the DUT sits in IDLE; it must be ignored.
  task automatic release_reset();
    outstanding = 0;
    dropped     = 0;
    expq.delete();
    mpc         = RPC;
    exp_stall   = '0;
    @(posedge clock);
    #2;
    reset_n        = 1'b1;
    redirect_valid = 1'b0;
    icache_ack     = 1'b1;
    icache_data    = {$urandom, $urandom, $urandom, $urandom};
    inst_ready     = 1'b1;
  endtask

  always @(negedge clock) begin
    if (reset_n && !redirect_valid) begin
      if (inst_valid && inst_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_inst", 32'(inst_valid), 32'd0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("inst", inst, e.ins);
          chk("inst_pc", inst_pc, e.pc);
          pops++;
        end
      end else if (expq.size() == 0) begin
        chk("empty_inst_valid", 32'(inst_valid), 32'd0);
      end
    end
  end

  initial begin
    int start;
    #12;
    check_reset_outputs();
    release_reset();

    // Decode stalled: exactly two lines fit, then fetch must stop.
    ready_pct = 0; max_lat = 1; start = reads;
    run(30);
    chk("stall_two_lines", 32'(reads - start), 32'd2);
    chk("stall_no_read", 32'(icache_read), 32'd0);

    ready_pct = 100;
    run(20);

    // Redirect while IDLE with a full queue: partial line from 0x108.
    ready_pct = 0;
    run(12);
    ftgt = 32'h0000_0108; fmode = 1;
    step();
    ready_pct = 100;
    run(20);

    // Redirect mid-WAIT with a slow ack: line drained and dropped.
    ftgt = 32'h0000_0200; fmode = 2;
    for (int i = 0; i < 40 && fmode != 0; i++) begin
      if (outstanding == 0) flat = 6;
      step();
    end
    chk("redirect_wait_done", 32'(fmode), 32'd0);
    run(20);

    // Redirect on the ack cycle.
    max_lat = 3; ftgt = 32'h0000_0344; fmode = 3;
    for (int i = 0; i < 40 && fmode != 0; i++) step();
    chk("redirect_ack_done", 32'(fmode), 32'd0);
    run(20);

    // Random traffic.
    ready_pct = 70; redir_pct = 5; max_lat = 6;
    run(1500);

    // Reset in the middle of WAIT.
    redir_pct = 0; ready_pct = 100; max_lat = 5;
    for (int i = 0; i < 50 && !(outstanding && waitc > 1); i++) step();
    chk("reached_wait", 32'(outstanding), 32'd1);
    #1 reset_n = 1'b0;
    #1 check_reset_outputs();
    release_reset();
    run(40);

    // Throughput with decode always ready.
    start = pops; max_lat = 1;
    run(60);
    chk("throughput", 32'((pops - start) >= 30), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
